// File: rtl/tile_packet_deserializer.sv
// tile_packet_deserializer: assembles one tile from a UART byte stream.
// A packet is a header byte (PKT_TYPE_READ_RESULT) followed by TILE_BITS/8
// payload bytes, first byte landing in the tile MSBs. A finished tile is
// published on tile_data with a one-cycle tile_stb. Stray bytes, idle gaps
// of TIMEOUT_CYCLES and bad checksums raise a one-cycle pkt_err.
// Optional feature: define TILE_PACKET_CHECKSUM_EN to append an XOR checksum
// byte to every packet (extra CHECK state).
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   tile_stb   one-cycle pulse, new tile on tile_data
//   tile_data  last assembled tile, stable between strobes
//   pkt_err    one-cycle pulse on a dropped or aborted packet
//   busy       high while inside a packet
module tile_packet_deserializer #(
  parameter int unsigned TILE_BITS            = 288,
  parameter int unsigned TIMEOUT_CYCLES       = 500000,
  parameter logic [7:0]  PKT_TYPE_READ_RESULT = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 tile_stb,
  output logic [TILE_BITS-1:0] tile_data,
  output logic                 pkt_err,
  output logic                 busy
);

  localparam int unsigned TILE_BYTES = TILE_BITS / 8;
  localparam int unsigned CNT_W      = $clog2(TILE_BYTES + 1);
  localparam int unsigned GAP_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef TILE_PACKET_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    PAYLOAD = 2'd1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [TILE_BITS-1:0] shift_q, shift_d;
  logic [TILE_BITS-1:0] tile_q, tile_d;
  logic                 stb_q, stb_d;
  logic                 err_q, err_d;
  logic                 busy_q;
`ifdef TILE_PACKET_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      tile_q  <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TILE_PACKET_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      tile_q  <= tile_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
`ifdef TILE_PACKET_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    tile_d  = tile_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
`ifdef TILE_PACKET_CHECKSUM_EN
    xor_d   = xor_q;
`endif

    if (state_q == IDLE) begin
      if (rx_valid) begin
        if (rx_data == PKT_TYPE_READ_RESULT) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          gap_d   = '0;
          shift_d = '0;
`ifdef TILE_PACKET_CHECKSUM_EN
          xor_d   = '0;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (!rx_valid) begin
      // Idle gap inside a packet; a byte arriving on the expiry cycle wins
      if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        gap_d   = '0;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
      case (state_q)
        PAYLOAD: begin
          // Header-valued bytes here are plain data
          shift_d = {shift_q[TILE_BITS-9:0], rx_data};
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef TILE_PACKET_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
          if (cnt_q == CNT_W'(TILE_BYTES - 1)) begin
`ifdef TILE_PACKET_CHECKSUM_EN
            state_d = CHECK;
`else
            tile_d  = shift_d;
            stb_d   = 1'b1;
            state_d = IDLE;
`endif
          end
        end
`ifdef TILE_PACKET_CHECKSUM_EN
        CHECK: begin
          state_d = IDLE;
          if (rx_data == xor_q) begin
            tile_d = shift_q;
            stb_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign tile_stb  = stb_q;
  assign tile_data = tile_q;
  assign pkt_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: doc/tile_packet_deserializer.md
TILE_PACKET_DESERIALIZER -- requirements
Module: tile_packet_deserializer

Interface
REQ-001 SHALL have parameter TILE_BITS, default 288, giving tile width in bits (16 elements x 18 bits); it SHALL be a multiple of 8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000, giving the maximum idle gap allowed between bytes inside a packet.
REQ-003 SHALL have parameter PKT_TYPE_READ_RESULT, default 8'h01, giving the header byte that opens a tile packet.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data holds a received UART byte.
REQ-007 rx_data  input  8  received byte.
REQ-008 tile_stb  output  1  one-cycle pulse; tile_data holds a complete tile, used as the L3 cache FIFO write enable.
REQ-009 tile_data  output  TILE_BITS  assembled tile, held stable until the next tile_stb.
REQ-010 pkt_err  output  1  one-cycle pulse on a dropped or aborted packet.
REQ-011 busy  output  1  high while the block is inside a packet (state other than IDLE).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, PAYLOAD, CHECK.
REQ-013 IDLE: rx_valid with rx_data==PKT_TYPE_READ_RESULT -> PAYLOAD with byte count 0 and the shift register cleared.
REQ-014 IDLE: rx_valid with any other byte -> stay in IDLE and pulse pkt_err next cycle.
REQ-015 PAYLOAD: each rx_valid shifts rx_data into the shift LSB (the first payload byte ends at bits [TILE_BITS-1:TILE_BITS-8]) and increments the byte count.
REQ-016 PAYLOAD: on the (TILE_BITS/8)th byte, with checksum compiled out, tile_data is loaded and tile_stb pulses the next cycle (1-cycle latency from the last rx_valid); FSM -> IDLE.
REQ-017 Byte count SHALL be ceil(log2(TILE_BITS/8+1)) bits wide and SHALL never exceed TILE_BITS/8; there is no wrap-around.
REQ-018 Gap counter SHALL clear on every accepted byte and increment each cycle in PAYLOAD/CHECK without rx_valid.
REQ-019 When the gap counter reaches TIMEOUT_CYCLES-1 -> IDLE, partial tile discarded, pkt_err pulses next cycle, tile_data unchanged.
REQ-020 rx_valid in the same cycle as timeout expiry: the byte SHALL be accepted and no timeout is taken.
REQ-021 A header byte value appearing inside the payload SHALL be treated as data; there is no resynchronisation mid-packet.
REQ-022 tile_stb and pkt_err SHALL never be high in the same cycle.
REQ-023 Back-to-back packets SHALL be accepted: a header byte on the cycle right after tile_stb is honoured.
REQ-024 rx_valid SHALL be honoured every cycle; there is no backpressure and the downstream FIFO's overflow is its own o_err.

Reset
REQ-025 reset SHALL force FSM=IDLE, byte count=0, gap counter=0, shift register=0, tile_data=0, tile_stb=0, pkt_err=0, busy=0.
REQ-026 reset mid-packet SHALL discard the partial tile and SHALL produce no tile_stb or pkt_err.

Configuration
REQ-027 Macro TILE_PACKET_CHECKSUM_EN, when defined, SHALL make the last payload byte go to CHECK instead of IDLE; the next byte is a checksum equal to the XOR of all payload bytes.
REQ-028 With TILE_PACKET_CHECKSUM_EN defined: checksum match -> tile_data load plus tile_stb next cycle; mismatch -> pulse pkt_err, tile_data unchanged; both cases -> IDLE; the CHECK state is also subject to timeout.
REQ-029 Without TILE_PACKET_CHECKSUM_EN, the CHECK state and XOR accumulator SHALL be absent and the packet is exactly 1+TILE_BITS/8 bytes.

Verification
REQ-030 After reset, send 01 then bytes 00..23 (hex, 36 bytes) -> exactly one tile_stb, 1 cycle after last byte; tile_data[287:280]=00, tile_data[7:0]=23.
REQ-031 Send byte 7F in IDLE -> pkt_err pulse, busy stays 0, no tile_stb; a following valid packet completes normally.
REQ-032 Send 01 plus 10 payload bytes, then idle TIMEOUT_CYCLES (set to 100) -> pkt_err at cycle 100, busy falls, tile_data keeps its prior value.
REQ-033 Assert reset after 20 payload bytes, then send a full packet of all AA -> one tile_stb, tile_data = all AA, no pkt_err.
REQ-034 With TILE_PACKET_CHECKSUM_EN: 36 payload bytes of 01 plus checksum 00 -> tile_stb; repeat with checksum 01 -> pkt_err, no tile_stb.
REQ-035 Two packets back-to-back with rx_valid every cycle -> two tile_stb pulses 37 cycles apart (38 with the checksum enabled).
